// File: rtl/dp_pkg.sv
// Shared encodings for the 8-bit multicycle datapath: ALU ops, operand/PC
// select codes and instruction-register field positions.
package dp_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_JOFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_ZERO   = 2'b11;

    localparam int IR_OP_LSB    = 26;
    localparam int IR_RS_LSB    = 21;
    localparam int IR_RT_LSB    = 16;
    localparam int IR_RD_LSB    = 11;
    localparam int IR_FUNCT_LSB = 0;
    localparam int IR_IMM_LSB   = 0;

endpackage

// File: rtl/dp_regfile.sv
// Register file: 2 combinational read ports, 1 synchronous write port, r0 reads 0.
// Define DP_RF_RESET_EN to clear every entry on rst_n.
module dp_regfile
    import dp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               clk,
`ifdef DP_RF_RESET_EN
    input  logic               rst_n,
`endif
    input  logic               we,
    input  logic [REGBITS-1:0] ra1,
    input  logic [REGBITS-1:0] ra2,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2
);

    localparam int NREG = 2 ** REGBITS;

    logic [WIDTH-1:0] r_mem [NREG];

`ifdef DP_RF_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (we && (wa != '0)) begin
            r_mem[wa] <= wd;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we && (wa != '0)) r_mem[wa] <= wd;
    end
`endif

    // Entry 0 is never written; the read mux forces it to zero in both builds.
    assign rd1 = (ra1 == '0) ? '0 : r_mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 : r_mem[ra2];

endmodule

// File: rtl/datapath_test_design.sv
// 8-bit multicycle MIPS datapath (PC, byte-assembled IR, regfile, ALU, A/B/ALUOut/MDR).
// Optional macro DP_RF_RESET_EN makes rst_n also clear the register file.
module datapath_test_design
    import dp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pcen,
    input  logic             iord,
    input  logic [3:0]       irwrite,
    input  logic             regdst,
    input  logic             memtoreg,
    input  logic             regwrite,
    input  logic             alusrca,
    input  logic [1:0]       alusrcb,
    input  logic [2:0]       alucont,
    input  logic [1:0]       pcsource,
    input  logic [WIDTH-1:0] memdata,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic             zero,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0]   r_pc;
    logic [31:0]        r_ir;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_aluout;
    logic [WIDTH-1:0]   r_mdr;

    logic [REGBITS-1:0] w_rs;
    logic [REGBITS-1:0] w_rt;
    logic [REGBITS-1:0] w_rd;
    logic [REGBITS-1:0] w_wa;
    logic [WIDTH-1:0]   w_wd;
    logic [WIDTH-1:0]   w_rd1;
    logic [WIDTH-1:0]   w_rd2;
    logic [WIDTH-1:0]   w_imm;
    logic [WIDTH-1:0]   w_joff;
    logic [WIDTH-1:0]   w_srca;
    logic [WIDTH-1:0]   w_srcb;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_pcnext;
    logic               w_unused_ir;

    function automatic logic [WIDTH-1:0] alu_f(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b,
                                               input logic [2:0]              ctl);
        logic [WIDTH-1:0] res;
        res = '0;
        case (ctl)
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: res = '0;
        endcase
        return res;
    endfunction

    assign w_rs   = r_ir[IR_RS_LSB +: REGBITS];
    assign w_rt   = r_ir[IR_RT_LSB +: REGBITS];
    assign w_rd   = r_ir[IR_RD_LSB +: REGBITS];
    assign w_imm  = WIDTH'(r_ir[IR_IMM_LSB +: 8]);
    assign w_joff = WIDTH'({r_ir[IR_FUNCT_LSB +: 6], 2'b00});
    assign w_unused_ir = ^{r_ir[25:24], r_ir[20:19], r_ir[15:14], r_ir[10:8]};

    assign w_wa = regdst ? w_rd : w_rt;
    assign w_wd = memtoreg ? r_mdr : r_aluout;

    dp_regfile #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_rf (
        .clk (clk),
`ifdef DP_RF_RESET_EN
        .rst_n (rst_n),
`endif
        .we  (regwrite),
        .ra1 (w_rs),
        .ra2 (w_rt),
        .wa  (w_wa),
        .wd  (w_wd),
        .rd1 (w_rd1),
        .rd2 (w_rd2)
    );

    assign w_srca = alusrca ? r_a : r_pc;

    always_comb begin
        w_srcb = r_b;
        case (alusrcb)
            SRCB_REG:  w_srcb = r_b;
            SRCB_ONE:  w_srcb = WIDTH'(1);
            SRCB_IMM:  w_srcb = w_imm;
            SRCB_JOFF: w_srcb = w_joff;
            default:   w_srcb = r_b;
        endcase
    end

    assign w_alu = alu_f(w_srca, w_srcb, alucont);

    always_comb begin
        w_pcnext = w_alu;
        case (pcsource)
            PC_ALU:    w_pcnext = w_alu;
            PC_ALUOUT: w_pcnext = r_aluout;
            PC_JUMP:   w_pcnext = w_joff;
            PC_ZERO:   w_pcnext = '0;
            default:   w_pcnext = w_alu;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            if (pcen) r_pc <= w_pcnext;
            for (int i = 0; i < 4; i++) begin
                if (irwrite[i]) r_ir[8*i +: 8] <= memdata[7:0];
            end
            r_a      <= w_rd1;
            r_b      <= w_rd2;
            r_aluout <= w_alu;
            r_mdr    <= memdata;
        end
    end

    assign op    = r_ir[IR_OP_LSB +: 6];
    assign funct = r_ir[IR_FUNCT_LSB +: 6];
    assign zero  = (w_alu == '0);
    assign addr  = iord ? r_aluout : r_pc;
    assign wdata = r_b;

endmodule

// File: tb/tb_datapath_test_design.sv
// Directed scoreboard bench for the multicycle datapath: expected values are
// queued as each step is driven and popped when the DUT outputs are sampled.
module tb_datapath_test_design;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pcen, iord, regdst, memtoreg, regwrite, alusrca;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucont;
    logic [7:0] memdata;
    logic [5:0] op, funct;
    logic       zero;
    logic [7:0] addr, wdata;

    int checks   = 0;
    int failures = 0;
    logic [7:0] pc_m;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    datapath_test_design #(.WIDTH(8), .REGBITS(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pcen     (pcen),
        .iord     (iord),
        .irwrite  (irwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .alucont  (alucont),
        .pcsource (pcsource),
        .memdata  (memdata),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .addr     (addr),
        .wdata    (wdata)
    );

    task automatic expect_v(input string tag, input logic [7:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_v(input logic [7:0] obs);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp)
            else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch cycle: load the selected IR lanes and advance PC by one.
    task automatic fetch(input logic [7:0] b, input logic [3:0] lanes);
        iord = 1'b0; alusrca = 1'b0; alusrcb = 2'b01; alucont = 3'b010;
        pcsource = 2'b00; pcen = 1'b1; irwrite = lanes; memdata = b; regwrite = 1'b0;
        step();
        pc_m = pc_m + 8'd1;
        irwrite = 4'b0000;
        pcen = 1'b0;
    endtask

    // Four byte fetches followed by a decode cycle that loads A and B.
    task automatic load_ir(input logic [31:0] ins);
        for (int i = 0; i < 4; i++) fetch(ins[8*i +: 8], 4'(1 << i));
        step();
    endtask

    task automatic exec_imm_add();
        alusrca = 1'b1; alusrcb = 2'b10; alucont = 3'b010;
        step();
    endtask

    task automatic write_back(input logic dst, input logic m2r);
        regdst = dst; memtoreg = m2r; regwrite = 1'b1;
        step();
        regwrite = 1'b0;
    endtask

    logic [2:0] sweep_op  [6] = '{3'b110, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011};
    logic [7:0] sweep_res [6] = '{8'h02, 8'h00, 8'h01, 8'h07, 8'h08, 8'h00};

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pcen = 1'b0; iord = 1'b0; irwrite = 4'b0; regdst = 1'b0;
        memtoreg = 1'b0; regwrite = 1'b0; alusrca = 1'b0; alusrcb = 2'b0;
        alucont = 3'b0; pcsource = 2'b0; memdata = 8'h00; pc_m = 8'h00;

        #1;
        expect_v("reset_addr", 8'h00);  check_v(addr);
        expect_v("reset_op", 8'h00);    check_v({2'b0, op});
        expect_v("reset_funct", 8'h00); check_v({2'b0, funct});
        step(); step();
        rst_n = 1'b1;

        fetch(8'hAA, 4'b0001);
        expect_v("fetch1_addr", pc_m);   check_v(addr);
        expect_v("fetch1_funct", 8'h2A); check_v({2'b0, funct});

        fetch(8'hFF, 4'b1111);
        expect_v("multilane_op", 8'h3F);    check_v({2'b0, op});
        expect_v("multilane_funct", 8'h3F); check_v({2'b0, funct});
        expect_v("multilane_addr", pc_m);   check_v(addr);

        load_ir(32'h0022_1020);
        expect_v("asm_op", 8'h00);    check_v({2'b0, op});
        expect_v("asm_funct", 8'h20); check_v({2'b0, funct});
        expect_v("asm_pc", pc_m);     check_v(addr);

        // addi r1, r0, 5
        load_ir(32'h2001_0005);
        expect_v("addi_op", 8'h08); check_v({2'b0, op});
        alusrca = 1'b1; alusrcb = 2'b10; alucont = 3'b010; #1;
        expect_v("addi_zero", 8'h00); check_v({7'b0, zero});
        step();
        iord = 1'b1; #1;
        expect_v("addi_aluout", 8'h05); check_v(addr);
        write_back(1'b0, 1'b0);
        step();
        expect_v("r1_readback", 8'h05); check_v(wdata);

        // write to r0 (rd field is 0) must be discarded
        write_back(1'b1, 1'b0);
        step();
        alusrca = 1'b1; alusrcb = 2'b10; alucont = 3'b000; #1;
        expect_v("r0_stays_zero", 8'h01); check_v({7'b0, zero});

        // addi r2, r0, 3
        load_ir(32'h2002_0003);
        exec_imm_add();
        write_back(1'b0, 1'b0);

        // R-type rs=r1, rt=r2, rd=r3
        load_ir(32'h0022_1820);
        expect_v("rtype_wdata_b", 8'h03); check_v(wdata);
        alusrca = 1'b1; alusrcb = 2'b00; iord = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alucont = sweep_op[i]; #1;
            expect_v($sformatf("zero_op%0b", sweep_op[i]), (sweep_res[i] == 8'h00) ? 8'h01 : 8'h00);
            check_v({7'b0, zero});
            step();
            expect_v($sformatf("aluout_op%0b", sweep_op[i]), sweep_res[i]);
            check_v(addr);
        end

        // rs=rt=r1: SUB gives zero, ADD result written to rd=r3
        load_ir(32'h0021_1820);
        alusrca = 1'b1; alusrcb = 2'b00; alucont = 3'b110; #1;
        expect_v("sub_self_zero", 8'h01); check_v({7'b0, zero});
        alucont = 3'b010;
        step();
        write_back(1'b1, 1'b0);

        // lw r3, 4(r0)
        load_ir(32'h8C03_0004);
        expect_v("lw_op", 8'h23);         check_v({2'b0, op});
        expect_v("rd_write_r3", 8'h0A);   check_v(wdata);
        exec_imm_add();
        iord = 1'b1; #1;
        expect_v("lw_addr", 8'h04); check_v(addr);
        memdata = 8'h3C;
        step();
        write_back(1'b0, 1'b1);
        memtoreg = 1'b0; memdata = 8'h00;
        step();
        expect_v("lw_r3_mdr", 8'h3C); check_v(wdata);

        // jump: IR[7:0]=CC (signed -52), IR[5:0]<<2 = 30
        load_ir(32'h0800_00CC);
        alusrca = 1'b1; alusrcb = 2'b10; alucont = 3'b111; #1;
        expect_v("slt_neg_imm", 8'h01); check_v({7'b0, zero});
        alusrcb = 2'b11; #1;
        expect_v("slt_pos_joff", 8'h00); check_v({7'b0, zero});
        step();
        iord = 1'b1; #1;
        expect_v("slt_aluout", 8'h01); check_v(addr);
        alusrcb = 2'b10; alucont = 3'b110;
        step();
        iord = 1'b0; pcsource = 2'b10; pcen = 1'b1;
        step();
        pcen = 1'b0;
        expect_v("jump_pc", 8'h30); check_v(addr);
        step();
        expect_v("pc_hold", 8'h30); check_v(addr);
        pcsource = 2'b01; pcen = 1'b1;
        step();
        pcen = 1'b0;
        expect_v("pc_from_aluout", 8'h34); check_v(addr);
        pcsource = 2'b11; pcen = 1'b1;
        step();
        pcen = 1'b0;
        expect_v("pc_zero", 8'h00); check_v(addr);

        // mid-cycle asynchronous reset
        pcsource = 2'b10; pcen = 1'b1;
        step();
        pcen = 1'b0;
        expect_v("pre_reset_pc", 8'h30); check_v(addr);
        #2 rst_n = 1'b0;
        #1;
        expect_v("async_reset_addr", 8'h00);  check_v(addr);
        expect_v("async_reset_op", 8'h00);    check_v({2'b0, op});
        expect_v("async_reset_funct", 8'h00); check_v({2'b0, funct});
        expect_v("async_reset_wdata", 8'h00); check_v(wdata);
        step();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
